// File: rtl/coeff_sched.sv
// coeff_sched: round-robin block scheduler with DC prediction, sequencing the coeff encoder
module coeff_sched #(
  parameter int B = 64,
  parameter int C = 110,
  parameter int W = 12,
  parameter int N = 3,
  parameter int TMO = 4096,
  localparam int NW = (N > 1) ? $clog2(N) : 1,
  localparam int TW = $clog2(TMO + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_valid,
  input  logic signed [W-1:0] req_blk [N][B],
  output logic [N-1:0]        req_ready,
  input  logic                frame_clr,
  output logic signed [W-1:0] enc_val [B],
  output logic                enc_start,
  input  logic                enc_done,
  input  logic [C:0]          enc_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [C:0]          out_code,
  output logic [NW-1:0]       out_comp,
  output logic                busy,
  output logic                err
);
  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  state_t state_q, state_d;
  logic [NW-1:0] last_q, last_d, comp_q, comp_d, out_comp_q, out_comp_d, win, idx;
  logic signed [W-1:0] pred_q [N];
  logic signed [W-1:0] pred_d [N];
  logic signed [W-1:0] enc_val_q [B];
  logic signed [W-1:0] enc_val_d [B];
  logic [C:0] out_code_q, out_code_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, found, accept;
  logic signed [W-1:0] p_eff, dc_sat;
  logic signed [W:0] diff;
  always_comb begin
    win = last_q;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = NW'((int'(last_q) + k) % N);
      if (!found && req_valid[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign req_ready = (state_q == IDLE && found) ? N'(1) << win : '0;
  assign accept = |(req_valid & req_ready);
  // a coincident frame_clr predicts from zero
  assign p_eff = frame_clr ? '0 : pred_q[win];
  assign diff = (W+1)'(req_blk[win][0]) - (W+1)'(p_eff);
  assign dc_sat = (diff[W] == diff[W-1]) ? diff[W-1:0] : (diff[W] ? SMIN : SMAX);
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    comp_d = comp_q;
    out_code_d = out_code_q;
    out_comp_d = out_comp_q;
    cnt_d = '0;
    err_d = err_q;
    enc_val_d = enc_val_q;
    pred_d = pred_q;
    if (frame_clr) pred_d = '{default: '0};
    case (state_q)
      IDLE: if (accept) begin
        enc_val_d = req_blk[win];
        enc_val_d[0] = dc_sat;
        pred_d[win] = req_blk[win][0];
        last_d = win;
        comp_d = win;
        state_d = START;
      end
      START: state_d = WAIT;
      // done from the previous block may linger into the first WAIT cycle
      WAIT: if (cnt_q != '0 && enc_done) begin
        out_code_d = enc_code;
        out_comp_d = comp_q;
        state_d = OUT;
      end else if (cnt_q == TW'(TMO - 1)) begin
        err_d = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q <= NW'(N - 1);
      comp_q <= '0;
      out_code_q <= '0;
      out_comp_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      enc_val_q <= '{default: '0};
      pred_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      comp_q <= comp_d;
      out_code_q <= out_code_d;
      out_comp_q <= out_comp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      enc_val_q <= enc_val_d;
      pred_q <= pred_d;
    end
  end
  assign enc_val = enc_val_q;
  assign enc_start = state_q == START;
  assign out_valid = state_q == OUT;
  assign busy = state_q != IDLE;
  assign out_code = out_code_q;
  assign out_comp = out_comp_q;
  assign err = err_q;
endmodule

// File: tb/tb_coeff_sched.sv
// tb_coeff_sched: table-driven directed bench for coeff_sched with a behavioural encoder
module tb_coeff_sched;
  localparam int B = 64, C = 110, W = 12, N = 3, TMO = 4096;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready;
  logic signed [W-1:0] req_blk [N][B];
  logic frame_clr;
  logic signed [W-1:0] enc_val [B];
  logic enc_start, enc_done, out_valid, out_ready, busy, err;
  logic [C:0] enc_code, out_code;
  logic [1:0] out_comp;
  coeff_sched #(.B(B), .C(C), .W(W), .N(N), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_blk(req_blk), .req_ready(req_ready),
    .frame_clr(frame_clr), .enc_val(enc_val), .enc_start(enc_start), .enc_done(enc_done),
    .enc_code(enc_code), .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_comp(out_comp), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  int vecs = 0, errs = 0;
  task automatic chk(input string name, input logic [C:0] act, input logic [C:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // encoder model: done rises enc_lat cycles after start, falls two cycles after the next start
  int enc_lat = 0, enc_cnt = 0, enc_clr = 0;
  logic [C:0] enc_next = '0;
  initial begin
    enc_done = 1'b0;
    enc_code = '0;
    forever begin
      @(negedge clk);
      if (enc_start) begin
        enc_cnt = enc_lat;
        enc_clr = 2;
      end else begin
        if (enc_clr > 0) begin
          enc_clr--;
          if (enc_clr == 0) enc_done = 1'b0;
        end
        if (enc_cnt > 0) begin
          enc_cnt--;
          if (enc_cnt == 0) begin
            enc_done = 1'b1;
            enc_code = enc_next;
          end
        end
      end
    end
  end
  typedef struct {
    logic [N-1:0] valid;
    int dc0, dc1, dc2;
    logic clr;
    int lat, hold;
    logic [C:0] code;
    logic [N-1:0] grant;
    int comp, exp_dc;
  } vec_t;
  vec_t vt [14];
  task automatic do_vec(input int k, input vec_t v);
    int seen, starts;
    @(negedge clk);
    req_blk[0][0] = W'(v.dc0);
    req_blk[1][0] = W'(v.dc1);
    req_blk[2][0] = W'(v.dc2);
    req_valid = v.valid;
    frame_clr = v.clr;
    enc_lat = v.lat;
    enc_next = v.code;
    #1 chk($sformatf("v%0d grant", k), req_ready, v.grant);
    @(posedge clk);
    #1 req_valid = '0;
    frame_clr = 1'b0;
    chk($sformatf("v%0d dc", k), enc_val[0], v.exp_dc);
    chk($sformatf("v%0d val3", k), enc_val[3], (v.comp == 0) ? -12 : v.comp * 10 + 3);
    seen = 0;
    starts = 0;
    for (int c = 1; c <= 200 && seen == 0; c++) begin
      @(negedge clk);
      if (enc_start) starts++;
      if (out_valid) seen = c;
    end
    chk($sformatf("v%0d latency", k), seen, v.lat + 2);
    chk($sformatf("v%0d starts", k), starts, 1);
    chk($sformatf("v%0d code", k), out_code, v.code);
    chk($sformatf("v%0d comp", k), out_comp, v.comp);
    req_valid = '1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk($sformatf("v%0d stall%0d flags", k, h), {out_valid, req_ready}, {1'b1, 3'b000});
      chk($sformatf("v%0d stall%0d code", k, h), out_code, v.code);
    end
    req_valid = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk($sformatf("v%0d idle", k), {busy, out_valid}, 2'b00);
    chk($sformatf("v%0d held", k), enc_val[0], v.exp_dc);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t va, vr;
    int errc, ov;
    vt[0]  = '{3'b001, -49, 0, 0, 1'b0, 20, 0, 111'hABC, 3'b001, 0, -49};
    vt[1]  = '{3'b001, -82, 0, 0, 1'b0, 6, 0, 111'h123, 3'b001, 0, -33};
    vt[2]  = '{3'b001, -82, 0, 0, 1'b1, 7, 0, 111'h456, 3'b001, 0, -82};
    vt[3]  = '{3'b100, 0, 0, 100, 1'b0, 5, 0, 111'h789, 3'b100, 2, 100};
    vt[4]  = '{3'b111, 10, 20, 30, 1'b0, 4, 0, 111'h111, 3'b001, 0, 92};
    vt[5]  = '{3'b111, 10, 20, 30, 1'b0, 4, 0, 111'h222, 3'b010, 1, 20};
    vt[6]  = '{3'b111, 10, 20, 30, 1'b0, 4, 0, 111'h333, 3'b100, 2, -70};
    vt[7]  = '{3'b111, 10, 20, 30, 1'b0, 4, 0, 111'h444, 3'b001, 0, 0};
    vt[8]  = '{3'b010, 0, 2047, 0, 1'b0, 3, 0, 111'h555, 3'b010, 1, 2027};
    vt[9]  = '{3'b010, 0, -2048, 0, 1'b0, 3, 0, 111'h666, 3'b010, 1, -2048};
    vt[10] = '{3'b010, 0, 2047, 0, 1'b0, 3, 0, 111'h777, 3'b010, 1, 2047};
    vt[11] = '{3'b001, 5, 0, 0, 1'b0, 8, 10, 111'h888, 3'b001, 0, -5};
    vt[12] = '{3'b100, 0, 0, -1, 1'b0, 2, 0, 111'h999, 3'b100, 2, -31};
    vt[13] = '{3'b110, 0, 0, 0, 1'b0, 3, 0, 111'h4000_0000_0000_0000_0000_0000_DEAD, 3'b010, 1, -2047};
    for (int n = 0; n < N; n++)
      for (int i = 0; i < B; i++)
        req_blk[n][i] = (n == 0) ? ((i == 3) ? W'(-12) : (i == 5) ? W'(-16) : W'(0)) : W'(n * 10 + i);
    rst = 1'b0;
    req_valid = '0;
    frame_clr = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk("reset flags", {busy, enc_start, out_valid, err}, 4'b0000);
    chk("reset ready", req_ready, 3'b000);
    chk("reset val0", enc_val[0], 0);
    chk("reset code", out_code, 0);
    for (int k = 0; k < 14; k++) do_vec(k, vt[k]);
    @(negedge clk) frame_clr = 1'b1;
    @(negedge clk) frame_clr = 1'b0;
    va = '{3'b001, -82, 0, 0, 1'b0, 5, 0, 111'hF00D, 3'b001, 0, -82};
    do_vec(99, va);
    @(negedge clk);
    req_blk[0][0] = W'(7);
    req_valid = 3'b001;
    enc_lat = 0;
    @(posedge clk);
    #1 req_valid = '0;
    errc = 0;
    ov = 0;
    for (int c = 1; c <= TMO + 50 && errc == 0; c++) begin
      @(negedge clk);
      if (out_valid) ov = 1;
      if (err) errc = c;
    end
    chk("timeout cycle", errc, TMO + 2);
    chk("timeout no output", ov, 0);
    chk("timeout idle", busy, 1'b0);
    @(negedge clk);
    req_blk[1][0] = W'(9);
    req_valid = 3'b010;
    #1 chk("post-timeout grant", req_ready, 3'b010);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (10) @(negedge clk);
    chk("err sticky", {err, busy}, 2'b11);
    #2 rst = 1'b0;
    #1 chk("midwait reset flags", {busy, enc_start, out_valid, err}, 4'b0000);
    chk("midwait reset val0", enc_val[0], 0);
    chk("midwait reset code", out_code, 0);
    chk("midwait reset ready", req_ready, 3'b000);
    @(negedge clk) rst = 1'b1;
    vr = '{3'b111, 3, 0, 0, 1'b0, 5, 0, 111'hC0DE, 3'b001, 0, 3};
    do_vec(100, vr);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/coeff_sched.md
# coeff_sched

Block scheduler in front of the `coeff` AC/DC entropy encoder. It arbitrates round-robin between N component sources (Y, Cb, Cr) that each offer a block of B quantised coefficients. For the winning block it replaces the DC term with its difference from that component's DC predictor, then sequences the encoder through start/done. The encoder's code word is returned on a valid/ready output tagged with the component index.

## Interface

Parameters:
- B, 64, coefficients per block
- C, 110, encoder code MSB index (code width C+1)
- W, 12, coefficient width, signed
- N, 3, number of requesters
- TMO, 4096, max cycles waiting for encoder done

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  N  requester n has a block on req_blk[n]
- req_blk  in  N×B×W  unpacked array req_blk[N][B], signed; held stable while req_valid
- req_ready  out  N  one-hot grant; accept = req_valid[n] & req_ready[n] at the edge
- frame_clr  in  1  synchronous clear of all DC predictors
- enc_val  out  B×W  registered block to encoder val_array, signed
- enc_start  out  1  one-cycle start pulse to encoder
- enc_done  in  1  encoder done level
- enc_code  in  C+1  encoder code word, valid while enc_done
- out_valid  out  1  out_code/out_comp valid
- out_ready  in  1  downstream accepts at edge when out_valid & out_ready
- out_code  out  C+1  captured code word
- out_comp  out  clog2(N)  component index of out_code
- busy  out  1  FSM not in IDLE
- err  out  1  sticky encoder-timeout flag

## Operation

- FSM states: IDLE, START, WAIT, OUT.
- IDLE:
  - Winner = first n with req_valid[n], searching from last_grant+1 modulo N.
  - req_ready[winner] is asserted combinationally; all other req_ready bits are 0.
  - On accept: enc_val[i] <= req_blk[w][i] for i ≥ 1.
  - On accept: enc_val[0] <= sat_W(req_blk[w][0] − pred[w]).
  - On accept: pred[w] <= req_blk[w][0], last_grant <= w, comp <= w, then go to START.
- START: enc_start = 1 for exactly one cycle, then go to WAIT.
- WAIT:
  - enc_done is ignored in the first WAIT cycle because the previous block's done may still be high.
  - From the second WAIT cycle, enc_done = 1 captures out_code <= enc_code and out_comp <= comp, sets out_valid, and goes to OUT.
  - A timeout counter counts WAIT cycles. At TMO cycles: err <= 1, the block is dropped, and the FSM goes to IDLE with no output.
- OUT: out_valid is held until out_ready, then the FSM goes to IDLE. out_code and out_comp are stable while out_valid is high.
- Arithmetic:
  - The difference is computed at W+1 bits.
  - sat_W clamps to [−2^(W−1), 2^(W−1)−1], i.e. [−2048, 2047].
  - pred[] is W-bit signed.
- frame_clr:
  - Clears every pred[] to 0 in any state.
  - If it coincides with an accept, the clear applies first: the difference uses 0 and pred[w] then loads the block's DC.
- enc_val is held unchanged outside accept edges.
- Reset (asynchronous, any state, including mid-WAIT):
  - FSM goes to IDLE.
  - enc_val, pred, out_code, out_comp, the counter and err go to 0.
  - enc_start, out_valid and busy go to 0.
  - last_grant goes to N−1, so the first grant after reset goes to requester 0.
  - req_ready resets to 0 and then follows the IDLE arbitration.
- err clears only on reset.

## Timing

- Accept edge = cycle 0. enc_start is high in cycle 1. WAIT begins in cycle 2.
- enc_done first honoured in cycle 3.
- enc_done seen at cycle k gives out_valid high from cycle k+1.
- Minimum accept-to-out_valid latency: 4 cycles.
- The out_ready handshake edge returns the FSM to IDLE. The next accept can happen in the following cycle, so there is one idle cycle between blocks.
- Only one block is in flight. req_ready is 0 in all states except IDLE.

## Test plan

- Reset, then offer req_blk[0] = {−49, 0, 0, −12, 0, −16, …}. Encoder model asserts done 20 cycles after start with code 0xABC.
  - Expect req_ready = 3'b001 and enc_val[0] = −49, enc_val[3] = −12.
  - Expect enc_start high for exactly 1 cycle.
  - Expect out_valid with out_code = 0xABC, out_comp = 0.
- Second Y block with DC −82 → enc_val[0] = −33. Assert frame_clr, then a Y block with DC −82 → enc_val[0] = −82.
- req_valid = 3'b111 held continuously → grant order 0, 1, 2, 0. Each pred[] is updated independently.
- pred[1] = 2047, then a Cb block with DC −2048 → enc_val[0] saturates to −2048. Reverse case (pred −2048, DC 2047) → 2047.
- out_ready held low for 10 cycles → out_valid and out_code remain stable, req_ready stays 0. Single-cycle out_ready → IDLE.
- enc_done never asserted → err = 1 exactly TMO cycles into WAIT, FSM returns to IDLE and out_valid stays 0. Drop rst mid-WAIT → all outputs 0 immediately, err cleared.
